// File: rtl/duty_ramp.sv
// Slew-rate limiter for a PWM duty input: walks the applied duty toward a
// requested target by a programmable step once per prescaler period.
module duty_ramp #(
  parameter int WIDTH = 10,
  parameter int DIV   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt_duty,
  input  logic             tgt_vld,
  input  logic [3:0]       step,
  input  logic             estop,
  output logic [WIDTH-1:0] duty,
  output logic             busy,
  output logic             at_tgt
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;

  logic             tick;
  logic [3:0]       step_eff;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   gap;

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the comb logic can leave one unassigned and infer a latch.
  always_comb begin
    step_eff = (step == 4'd0) ? 4'd1 : step;
    step_ext = {{(WIDTH-3){1'b0}}, step_eff};
    tick     = (cnt_q == CNT_W'(DIV - 1));
    sum      = {1'b0, duty_q} + step_ext;
    gap      = {1'b0, duty_q} - {1'b0, tgt_q};

    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    tgt_d   = tgt_vld ? tgt_duty : tgt_q;
    duty_d  = duty_q;
    state_d = IDLE;

    // Direction comes from the live comparison rather than the state, so a
    // target reversal that lands right before a tick never jumps the duty.
    if (tick) begin
      if (tgt_q > duty_q) begin
        duty_d = (sum >= {1'b0, tgt_q}) ? tgt_q : sum[WIDTH-1:0];
      end else if (tgt_q < duty_q) begin
        duty_d = (gap <= step_ext) ? tgt_q : duty_q - step_ext[WIDTH-1:0];
      end
    end

    // Same transition rule from every state: the registered comparison picks
    // the next state, which is why busy trails at_tgt by one edge.
    case (state_q)
      IDLE, UP, DOWN: begin
        if (tgt_q > duty_q)      state_d = UP;
        else if (tgt_q < duty_q) state_d = DOWN;
        else                     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (estop) begin
      cnt_d   = '0;
      tgt_d   = '0;
      duty_d  = '0;
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
    end
  end

  assign duty   = duty_q;
  assign busy   = (state_q != IDLE);
  assign at_tgt = (duty_q == tgt_q);

endmodule
